// File: rtl/pc_ras_if.sv
// Request/status bundle between fetch control and the PC/return-address-stack unit.
interface pc_ras_if #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic             ce;
    logic             branch;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] target;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus_one;
    logic [CNT_W-1:0] ras_count;
    logic             ras_empty;
    logic             ras_full;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output ce, branch, call, ret, target, clr_err,
        input  pc, pc_plus_one, ras_count, ras_empty, ras_full, ovf_err, unf_err
    );

    modport slave (
        input  ce, branch, call, ret, target, clr_err,
        output pc, pc_plus_one, ras_count, ras_empty, ras_full, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// Priority per enabled cycle: ret > call > branch > increment.
module pc_ras #(
    parameter int               WIDTH        = 16,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}}
) (
    input logic     clock,
    input logic     reset,
    pc_ras_if.slave bus
);
    localparam int               PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1'b1);

    logic [WIDTH-1:0] pc_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] sp_r;
    logic             ovf_r;
    logic             unf_r;
    logic [WIDTH-1:0] stack_r [RAS_DEPTH];

    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] pc_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [PTR_W-1:0] sp_nxt_s;
    logic [PTR_W-1:0] sp_inc_s;
    logic [PTR_W-1:0] sp_dec_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             ovf_set_s;
    logic             unf_set_s;

    assign pc_inc_s = pc_r + PC_ONE;
    assign empty_s  = (cnt_r == CNT_ZERO);
    assign full_s   = (cnt_r == CNT_FULL);
    // sp_r points at the next free slot; it wraps so a push while full overwrites the oldest entry
    assign sp_inc_s = (sp_r == PTR_LAST) ? PTR_ZERO : (sp_r + PTR_ONE);
    assign sp_dec_s = (sp_r == PTR_ZERO) ? PTR_LAST : (sp_r - PTR_ONE);

    // Next-state selection for pc, stack pointer, count and error events
    always_comb begin
        pc_nxt_s  = pc_r;
        cnt_nxt_s = cnt_r;
        sp_nxt_s  = sp_r;
        push_s    = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (bus.ce) begin
            if (bus.ret) begin
                if (!empty_s) begin
                    pc_nxt_s  = stack_r[sp_dec_s];
                    sp_nxt_s  = sp_dec_s;
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    pc_nxt_s  = pc_inc_s;
                    unf_set_s = 1'b1;
                end
            end else if (bus.call) begin
                push_s   = 1'b1;
                pc_nxt_s = bus.target;
                sp_nxt_s = sp_inc_s;
                if (full_s) begin
                    ovf_set_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end else if (bus.branch) begin
                pc_nxt_s = bus.target;
            end else begin
                pc_nxt_s = pc_inc_s;
            end
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Architectural state and sticky error flags; an error event beats a same-cycle clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r  <= RESET_VECTOR;
            cnt_r <= CNT_ZERO;
            sp_r  <= PTR_ZERO;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            pc_r  <= pc_nxt_s;
            cnt_r <= cnt_nxt_s;
            sp_r  <= sp_nxt_s;
            ovf_r <= ovf_set_s | (ovf_r & ~bus.clr_err);
            unf_r <= unf_set_s | (unf_r & ~bus.clr_err);
        end
    end

    // Stack storage carries no reset: entries beyond ras_count are never read
    always_ff @(posedge clock) begin
        if (push_s) begin
            stack_r[sp_r] <= pc_inc_s;
        end
    end

    assign bus.pc          = pc_r;
    assign bus.pc_plus_one = pc_inc_s;
    assign bus.ras_count   = cnt_r;
    assign bus.ras_empty   = empty_s;
    assign bus.ras_full    = full_s;
    assign bus.ovf_err     = ovf_r;
    assign bus.unf_err     = unf_r;
endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (WIDTH=16, RAS_DEPTH=4, RESET_VECTOR=0xFFFE).
module tb_pc_ras;
    logic clock;
    logic reset;
    int   err_cnt;
    int   chk_cnt;

    pc_ras_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

    pc_ras #(
        .WIDTH       (16),
        .RAS_DEPTH   (4),
        .RESET_VECTOR(16'hFFFE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle 1 time unit so outputs are sampled away from the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_req(input logic r, input logic c, input logic b, input logic [15:0] t);
        bus.ret    = r;
        bus.call   = c;
        bus.branch = b;
        bus.target = t;
    endtask

    initial begin
        err_cnt     = 0;
        chk_cnt     = 0;
        reset       = 1'b0;
        bus.ce      = 1'b0;
        bus.clr_err = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 16'h0000);
        #12;
        check_eq("rst_pc", bus.pc, 32'hFFFE);
        check_eq("rst_count", bus.ras_count, 32'd0);
        check_eq("rst_empty", bus.ras_empty, 32'd1);
        check_eq("rst_full", bus.ras_full, 32'd0);
        check_eq("rst_ovf", bus.ovf_err, 32'd0);
        check_eq("rst_unf", bus.unf_err, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // increment wrap
        bus.ce = 1'b1;
        step(1);
        check_eq("inc_pc_ffff", bus.pc, 32'hFFFF);
        check_eq("pc_plus_one_wrap", bus.pc_plus_one, 32'h0000);
        step(1);
        check_eq("inc_pc_0000", bus.pc, 32'h0000);
        step(1);
        check_eq("inc_pc_0001", bus.pc, 32'h0001);

        // branch and hold
        set_req(1'b0, 1'b0, 1'b1, 16'h0010);
        step(1);
        check_eq("br_pc_0010", bus.pc, 32'h0010);
        set_req(1'b0, 1'b0, 1'b1, 16'h0200);
        step(1);
        check_eq("br_pc_0200", bus.pc, 32'h0200);
        bus.ce = 1'b0;
        step(5);
        check_eq("hold_pc", bus.pc, 32'h0200);
        bus.ce = 1'b1;

        // nested call/return
        set_req(1'b0, 1'b0, 1'b1, 16'h0005);
        step(1);
        set_req(1'b0, 1'b1, 1'b0, 16'h0100);
        step(1);
        check_eq("call1_pc", bus.pc, 32'h0100);
        set_req(1'b0, 1'b1, 1'b0, 16'h0200);
        step(1);
        check_eq("call2_pc", bus.pc, 32'h0200);
        check_eq("call2_count", bus.ras_count, 32'd2);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1);
        check_eq("ret1_pc", bus.pc, 32'h0101);
        step(1);
        check_eq("ret2_pc", bus.pc, 32'h0006);
        check_eq("ret2_empty", bus.ras_empty, 32'd1);
        check_eq("nest_ovf", bus.ovf_err, 32'd0);
        check_eq("nest_unf", bus.unf_err, 32'd0);

        // overflow: calls from 0x1000, 0x2000, 0x3000, 0x4000, 0x5000
        set_req(1'b0, 1'b0, 1'b1, 16'h1000);
        step(1);
        for (int i = 1; i <= 4; i++) begin
            set_req(1'b0, 1'b1, 1'b0, 16'(i * 16'h1000 + 16'h1000));
            step(1);
        end
        check_eq("four_calls_full", bus.ras_full, 32'd1);
        check_eq("four_calls_ovf", bus.ovf_err, 32'd0);
        set_req(1'b0, 1'b1, 1'b0, 16'h6000);
        step(1);
        check_eq("ovf_pc", bus.pc, 32'h6000);
        check_eq("ovf_flag", bus.ovf_err, 32'd1);
        check_eq("ovf_count", bus.ras_count, 32'd4);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1);
        check_eq("ovf_ret1", bus.pc, 32'h5001);
        step(1);
        check_eq("ovf_ret2", bus.pc, 32'h4001);
        step(1);
        check_eq("ovf_ret3", bus.pc, 32'h3001);
        step(1);
        check_eq("ovf_ret4", bus.pc, 32'h2001);
        check_eq("ovf_ret_empty", bus.ras_empty, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 16'h0000);
        bus.ce      = 1'b0;
        bus.clr_err = 1'b1;
        step(1);
        check_eq("clr_ovf_no_ce", bus.ovf_err, 32'd0);
        check_eq("clr_no_ce_pc", bus.pc, 32'h2001);
        bus.clr_err = 1'b0;
        bus.ce      = 1'b1;

        // underflow and clear
        set_req(1'b0, 1'b0, 1'b1, 16'h0040);
        step(1);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1);
        check_eq("unf_pc", bus.pc, 32'h0041);
        check_eq("unf_flag", bus.unf_err, 32'd1);
        check_eq("unf_count", bus.ras_count, 32'd0);
        set_req(1'b0, 1'b0, 1'b0, 16'h0000);
        bus.clr_err = 1'b1;
        step(1);
        check_eq("unf_cleared", bus.unf_err, 32'd0);
        check_eq("clr_inc_pc", bus.pc, 32'h0042);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1);
        check_eq("unf_beats_clr", bus.unf_err, 32'd1);
        check_eq("unf_clr_pc", bus.pc, 32'h0043);
        bus.clr_err = 1'b0;

        // priority: ret beats call and branch
        set_req(1'b0, 1'b0, 1'b1, 16'h0032);
        step(1);
        set_req(1'b0, 1'b1, 1'b0, 16'h0500);
        step(1);
        check_eq("prio_push_count", bus.ras_count, 32'd1);
        set_req(1'b1, 1'b1, 1'b1, 16'h0777);
        step(1);
        check_eq("prio_pc", bus.pc, 32'h0033);
        check_eq("prio_count", bus.ras_count, 32'd0);

        // asynchronous reset mid-sequence
        set_req(1'b0, 1'b1, 1'b0, 16'h0100);
        step(2);
        check_eq("pre_rst_count", bus.ras_count, 32'd2);
        set_req(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        reset = 1'b0;
        #1;
        check_eq("async_rst_pc", bus.pc, 32'hFFFE);
        check_eq("async_rst_count", bus.ras_count, 32'd0);
        check_eq("async_rst_unf", bus.unf_err, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step(1);
        check_eq("post_rst_pc", bus.pc, 32'hFFFF);
        set_req(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1);
        check_eq("post_rst_ret_pc", bus.pc, 32'h0000);
        check_eq("post_rst_unf", bus.unf_err, 32'd1);
        set_req(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program-counter unit with an integrated return-address stack (RAS). It sits in the fetch stage. Each enabled cycle it selects the next instruction address: sequential increment, branch target, call target (pushing the return address) or return (popping it). It generalises the plain increment/branch PC with configurable width, reset vector, and call/return support with overflow and underflow reporting.

## Interface
- WIDTH, 16, address width in bits.
- RAS_DEPTH, 4, number of return-address entries; must be ≥2.
- RESET_VECTOR, 0, value of pc after reset (WIDTH bits).
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ce  input  1  change enable; when 0 no architectural state changes except error clear.
- branch  input  1  load pc from target.
- call  input  1  push pc+1, load pc from target.
- ret  input  1  pop top of stack into pc.
- target  input  WIDTH  branch/call destination.
- clr_err  input  1  synchronous clear of sticky error flags.
- pc  output  WIDTH  current instruction address (registered).
- pc_plus_one  output  WIDTH  combinational pc+1, modulo 2^WIDTH.
- ras_count  output  $clog2(RAS_DEPTH+1)  valid entries, registered.
- ras_empty  output  1  ras_count==0.
- ras_full  output  1  ras_count==RAS_DEPTH.
- ovf_err  output  1  sticky: call while full.
- unf_err  output  1  sticky: ret while empty.

## Operation
- Reset (reset=0, asynchronous):
  - pc=RESET_VECTOR, ras_count=0, stack pointer=0, ovf_err=0, unf_err=0.
  - Stack contents are don't-care.
- When ce=1, the action is chosen by priority ret > call > branch > increment. Lower-priority requests in the same cycle are ignored.
- Increment: pc ← pc+1, wrapping from 2^WIDTH−1 to 0.
- Branch: pc ← target.
- Call, stack not full:
  - Push pc+1 (wrapped); pc ← target; ras_count+1.
- Call, stack full:
  - Circular overwrite: the push replaces the oldest entry and the pointer wraps modulo RAS_DEPTH.
  - pc ← target; ras_count stays RAS_DEPTH; ovf_err ← 1.
- Ret, stack not empty: pc ← top entry; pointer and ras_count decrement.
- Ret, stack empty:
  - pc ← pc+1 (treated as increment); ras_count stays 0; unf_err ← 1.
- ce=0: pc, stack, pointer and ras_count hold; all request inputs are ignored.
- Error flags:
  - clr_err=1 clears both flags at the next edge, regardless of ce.
  - If an error event and clr_err occur in the same cycle, the event wins and the flag is set.
- All arithmetic is unsigned, modulo 2^WIDTH. The stack pointer is modulo RAS_DEPTH.

## Timing
- All state updates on the rising edge of clock; reset acts immediately.
- pc is visible one cycle after the enabled request, so effective latency is 1 cycle.
- pc_plus_one follows pc combinationally, with no added latency.
- The return address pushed is pc+1 of the calling cycle.
- A ret in the cycle immediately after a call returns that call's return address (back-to-back push/pop, no hazard).
- ras_count, ras_empty and ras_full reflect the post-edge state. ras_empty and ras_full are derived from the registered count.
- Reset asserted mid-sequence discards the whole stack. After release, the first enabled edge acts from RESET_VECTOR.

## Test plan
- Reset and increment wrap (WIDTH=16, RESET_VECTOR=0xFFFE):
  - Release reset, ce=1 for 3 cycles → pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - pc_plus_one at pc=0xFFFF is 0x0000.
- Branch and hold:
  - At pc=0x0010, branch=1, target=0x0200 → pc=0x0200.
  - Then ce=0 for 5 cycles with branch=1 → pc stays 0x0200.
- Nested call/return (RAS_DEPTH=4):
  - Call 0x0100 from pc=0x0005, then call 0x0200 from pc=0x0100 → ras_count=2.
  - ret → pc=0x0101; ret → pc=0x0006; ras_empty=1.
  - No error flags set.
- Overflow (RAS_DEPTH=4):
  - 5 successive calls from pcs A0..A4 → ovf_err=1, ras_count=4.
  - 4 rets yield A4+1, A3+1, A2+1, A1+1.
- Underflow and clear:
  - ret with empty stack at pc=0x0040 → pc=0x0041, unf_err=1.
  - clr_err=1 for one cycle → unf_err=0.
  - A simultaneous underflow and clr_err leaves unf_err=1.
- Priority and reset mid-operation:
  - ret+call+branch with 1 entry (value 0x0033) → pc=0x0033, ras_count=0.
  - After 2 pushes, assert reset asynchronously between edges → pc=RESET_VECTOR and ras_count=0 immediately.
